// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem read, 1-entry skid buffer, branch kill/redirect.
// Latency: word on ack -> if_valid next cycle; each completed read is followed by one idle request cycle.
// Backpressure: freeze holds the output; a word returning into a busy slot parks in the buffer and fetch pauses.

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD, ST_KILL} state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [31:0] r_pc;
    logic [31:0] w_pc_n;
    logic [31:0] r_addr;
    logic [31:0] w_addr_n;
    logic        r_req;
    logic        w_req_n;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_instr;
    logic        r_valid;
    logic        w_valid_n;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic [15:0] r_stall;
    logic        w_ack;
    logic        w_free;
    logic        w_out_mem;
    logic        w_out_buf;
    logic        w_buf_ld;
    logic [31:0] w_br_pc;
    logic [31:0] w_pc_inc;
    logic [1:0]  w_unused_tgt;

    // A request is live only while r_req is high; acks at any other time are noise.
    assign w_ack        = r_req & imem_ack;
    assign w_free       = ~r_valid | ~freeze;
    assign w_br_pc      = {br_target[31:2], 2'b00};
    assign w_pc_inc     = r_pc + 32'd4;
    assign w_unused_tgt = br_target[1:0];

    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_valid_n = r_valid & freeze;
        w_out_mem = 1'b0;
        w_out_buf = 1'b0;
        w_buf_ld  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_n = ST_REQ;
                if (br_taken) begin
                    w_pc_n    = w_br_pc;
                    w_valid_n = 1'b0;
                end
            end
            ST_REQ: begin
                if (br_taken) begin
                    w_pc_n    = w_br_pc;
                    w_valid_n = 1'b0;
                    w_state_n = (r_req & ~imem_ack) ? ST_KILL : ST_REQ;
                end else if (w_ack) begin
                    w_pc_n = w_pc_inc;
                    if (w_free) begin
                        w_out_mem = 1'b1;
                        w_valid_n = 1'b1;
                    end else begin
                        w_buf_ld  = 1'b1;
                        w_state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (br_taken) begin
                    w_pc_n    = w_br_pc;
                    w_valid_n = 1'b0;
                    w_state_n = ST_REQ;
                end else if (!freeze) begin
                    w_out_buf = 1'b1;
                    w_valid_n = 1'b1;
                    w_state_n = ST_REQ;
                end
            end
            ST_KILL: begin
                if (br_taken) begin
                    w_pc_n    = w_br_pc;
                    w_valid_n = 1'b0;
                end
                if (imem_ack) begin
                    w_state_n = ST_REQ;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        // Completing a read always forces one request-free cycle before the next one.
        w_req_n  = ((w_state_n == ST_REQ) || (w_state_n == ST_KILL)) && !w_ack;
        // The killed read keeps its address on the bus until memory answers it.
        w_addr_n = (w_state_n == ST_KILL) ? r_addr : w_pc_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_req       <= 1'b0;
            r_buf_pc    <= 32'd0;
            r_buf_instr <= 32'd0;
            r_valid     <= 1'b0;
            r_if_pc     <= 32'd0;
            r_if_instr  <= 32'd0;
            r_stall     <= 16'd0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_addr  <= w_addr_n;
            r_req   <= w_req_n;
            r_valid <= w_valid_n;
            if (w_buf_ld) begin
                r_buf_pc    <= r_pc;
                r_buf_instr <= imem_rdata;
            end
            if (w_out_mem) begin
                r_if_pc    <= r_pc;
                r_if_instr <= imem_rdata;
            end else if (w_out_buf) begin
                r_if_pc    <= r_buf_pc;
                r_if_instr <= r_buf_instr;
            end
            if (r_req && !imem_ack && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign if_valid  = r_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign stall_cnt = r_stall;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: transaction-level model (queue of delivered words, fetch pointer) plus directed cases.
// All inputs change 2 time units after the rising edge; outputs are sampled there as well.

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [15:0] stall_cnt;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_t;

    // Model: words returned by memory but not yet taken by decode, in order.
    fetch_t      q[$];
    logic [31:0] fptr;
    logic [31:0] cur_addr;
    bit          outstanding;
    bit          killed;
    bit          ack_prev;
    int          cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        fptr        = 32'h0;
        cur_addr    = 32'h0;
        outstanding = 1'b0;
        killed      = 1'b0;
        ack_prev    = 1'b0;
        cnt         = 0;
    endtask

    task automatic compare();
        chk("m_valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("m_if_pc", if_pc, q[0].pc);
            chk("m_if_instr", if_instr, q[0].ins);
        end
        chk("m_stall", {16'd0, stall_cnt}, cnt);
        if (ack_prev) chk("m_req_gap", {31'd0, imem_req}, 32'd0);
        if (q.size() >= 2) chk("m_req_full", {31'd0, imem_req}, 32'd0);
        if (imem_req) chk("m_addr", imem_addr, outstanding ? cur_addr : fptr);
    endtask

    task automatic model_step();
        bit hs;
        bit cons;
        hs   = imem_req && imem_ack;
        cons = (q.size() > 0) && !freeze;
        if (imem_req && !outstanding) begin
            cur_addr = fptr;
            killed   = 1'b0;
        end
        if (br_taken) begin
            q.delete();
            fptr = {br_target[31:2], 2'b00};
            if (imem_req) killed = 1'b1;
        end else begin
            if (cons) void'(q.pop_front());
            if (hs && !killed) begin
                q.push_back('{pc: cur_addr, ins: imem_rdata});
                fptr = cur_addr + 32'd4;
            end
        end
        outstanding = imem_req && !imem_ack;
        ack_prev    = hs;
        if (imem_req && !imem_ack && cnt < 65535) cnt++;
    endtask

    task automatic cyc();
        compare();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        model_reset();
        freeze = 1'b0; br_taken = 1'b0; br_target = 32'd0; imem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic run_until_pc(input logic [31:0] pc, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (if_valid && if_pc == pc) begin
                found = 1'b1;
            end else begin
                freeze = 1'b0; br_taken = 1'b0;
                imem_ack = imem_req; imem_rdata = $urandom;
                cyc();
            end
        end
    endtask

    initial begin
        bit          found;
        int          vcyc[$];
        logic [31:0] vpc[$];
        #2;

        // Streaming with an always-acking memory: 0,4,8,C every other cycle.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            freeze = 1'b0; br_taken = 1'b0;
            imem_ack = imem_req; imem_rdata = $urandom;
            if (i == 0) chk("t1_req_cycle1", {31'd0, imem_req}, 32'd0);
            if (i == 1) begin
                chk("t1_req_cycle2", {31'd0, imem_req}, 32'd1);
                chk("t1_addr_cycle2", imem_addr, 32'h0);
            end
            if (if_valid) begin
                vcyc.push_back(i);
                vpc.push_back(if_pc);
            end
            cyc();
        end
        chk("t1_count", vpc.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_pc", (k < vpc.size()) ? vpc[k] : 32'hFFFF_FFFF, 32'(4 * k));
            chk("t1_cycle", (k < vcyc.size()) ? 32'(vcyc[k]) : 32'hFFFF_FFFF, 32'(2 + 2 * k));
        end

        // Three wait cycles on address 0.
        do_reset();
        cyc();
        for (int w = 0; w < 4; w++) begin
            chk("t2_req", {31'd0, imem_req}, 32'd1);
            chk("t2_addr", imem_addr, 32'h0);
            imem_ack   = (w == 3);
            imem_rdata = (w == 3) ? 32'hDEAD_BEEF : $urandom;
            if (w == 3) chk("t2_stall", {16'd0, stall_cnt}, 32'd3);
            cyc();
        end
        imem_ack = 1'b0;
        chk("t2_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_pc", if_pc, 32'h0);
        chk("t2_instr", if_instr, 32'hDEAD_BEEF);
        chk("t2_stall_after", {16'd0, stall_cnt}, 32'd3);

        // Frozen output at 0x4 while the word for 0x8 returns.
        do_reset();
        run_until_pc(32'h4, 20, found);
        chk("t3_found", {31'd0, found}, 32'd1);
        for (int j = 0; j < 4; j++) begin
            freeze = 1'b1;
            imem_ack = imem_req;
            imem_rdata = (imem_req && imem_addr == 32'h8) ? 32'h8888_0008 : $urandom;
            chk("t3_hold_pc", if_pc, 32'h4);
            chk("t3_hold_valid", {31'd0, if_valid}, 32'd1);
            cyc();
        end
        chk("t3_hold_req", {31'd0, imem_req}, 32'd0);
        chk("t3_hold_pc_end", if_pc, 32'h4);
        freeze = 1'b0; imem_ack = 1'b0;
        cyc();
        chk("t3_next_pc", if_pc, 32'h8);
        chk("t3_next_instr", if_instr, 32'h8888_0008);
        chk("t3_next_valid", {31'd0, if_valid}, 32'd1);
        chk("t3_next_addr", imem_addr, 32'hC);

        // Branch to 0x103 while 0x10 is outstanding.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (imem_req && imem_addr == 32'h10) begin
                found = 1'b1;
            end else begin
                freeze = 1'b0; imem_ack = imem_req; imem_rdata = $urandom;
                cyc();
            end
        end
        chk("t4_found", {31'd0, found}, 32'd1);
        imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h103;
        cyc();
        br_taken = 1'b0;
        chk("t4_kill_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_kill_addr", imem_addr, 32'h10);
        cyc();
        chk("t4_kill_addr2", imem_addr, 32'h10);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        cyc();
        imem_ack = 1'b0;
        chk("t4_drop_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_gap", {31'd0, imem_req}, 32'd0);
        cyc();
        chk("t4_new_req", {31'd0, imem_req}, 32'd1);
        chk("t4_new_addr", imem_addr, 32'h100);
        imem_ack = 1'b1; imem_rdata = 32'h1111_0100;
        cyc();
        imem_ack = 1'b0;
        chk("t4_tgt_pc", if_pc, 32'h100);
        chk("t4_tgt_instr", if_instr, 32'h1111_0100);

        // Branch, freeze and ack in one cycle.
        do_reset();
        run_until_pc(32'h0, 20, found);
        chk("t5_found", {31'd0, found}, 32'd1);
        freeze = 1'b1; imem_ack = imem_req;
        cyc();
        chk("t5_req", {31'd0, imem_req}, 32'd1);
        chk("t5_frozen_pc", if_pc, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA; br_taken = 1'b1; br_target = 32'h200;
        cyc();
        br_taken = 1'b0; imem_ack = 1'b0; freeze = 1'b0;
        chk("t5_flush_valid", {31'd0, if_valid}, 32'd0);
        chk("t5_gap", {31'd0, imem_req}, 32'd0);
        cyc();
        chk("t5_tgt_req", {31'd0, imem_req}, 32'd1);
        chk("t5_tgt_addr", imem_addr, 32'h200);

        // Random traffic, light then heavy freeze.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            freeze    = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            br_taken  = ($urandom_range(0, 19) == 0);
            br_target = $urandom;
            imem_ack  = imem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
            cyc();
        end
        br_taken = 1'b0;

        // Stall counter saturation, then reset in the middle of the request.
        do_reset();
        run_until_pc(32'h10, 40, found);
        chk("t7_found", {31'd0, found}, 32'd1);
        freeze = 1'b1; imem_ack = 1'b0;
        for (int i = 0; i < 70000; i++) cyc();
        chk("t7_stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        chk("t7_pc_held", if_pc, 32'h10);
        chk("t7_req_held", {31'd0, imem_req}, 32'd1);
        do_reset();
        chk("t7_post_cycle1", {31'd0, imem_req}, 32'd0);
        cyc();
        chk("t7_post_req", {31'd0, imem_req}, 32'd1);
        chk("t7_post_addr", imem_addr, 32'h0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 freeze  input  1  hazard stall from decode; 1 = decode cannot accept the fetch output this cycle.
REQ-005 br_taken  input  1  single-cycle branch/jump redirect strobe from the execute stage.
REQ-006 br_target  input  32  absolute redirect address; bits [1:0] ignored, treated as 0.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  instruction-memory word address (byte address, bits [1:0]=0).
REQ-009 imem_ack  input  1  memory completion strobe; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  instruction word returned by memory.
REQ-011 if_valid  output  1  fetch output holds an unconsumed instruction.
REQ-012 if_pc  output  32  PC of the instruction on if_instr.
REQ-013 if_instr  output  32  fetched instruction.
REQ-014 stall_cnt  output  16  saturating count of memory wait cycles.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, HOLD and KILL, with a 32-bit internal pc_reg, a 1-entry buffer (buf_pc, buf_instr) and the output register (if_valid, if_pc, if_instr).
REQ-016 IDLE SHALL drive imem_req=0 and go to REQ on the next edge.
REQ-017 REQ and KILL SHALL drive imem_req=1; imem_addr SHALL equal pc_reg in REQ and stay stable until imem_ack.
REQ-018 The output is consumed in any cycle with if_valid=1 and freeze=0; the output slot is free when if_valid=0 or it is being consumed.
REQ-019 REQ, imem_ack=1, slot free: output loads {1, pc_reg, imem_rdata}; pc_reg += 4 (mod 2^32); stay in REQ; the next request issues the following cycle (one request per two cycles minimum).
REQ-020 REQ, imem_ack=1, slot not free: buffer loads {pc_reg, imem_rdata}; pc_reg += 4; go to HOLD.
REQ-021 HOLD SHALL drive imem_req=0; when freeze=0 the output consumes and the buffer moves into the output (if_valid stays 1); go to REQ.
REQ-022 No consumption with a free slot: if_valid SHALL clear; a frozen output SHALL hold if_pc/if_instr stable.
REQ-023 br_taken SHALL take priority over freeze and all other events: pc_reg <= {br_target[31:2],2'b00}, if_valid <= 0, buffer discarded.
REQ-024 br_taken in REQ with imem_ack=0: go to KILL; KILL keeps the old imem_addr until imem_ack, discards imem_rdata, then goes to REQ.
REQ-025 br_taken in REQ with imem_ack=1, or in HOLD or IDLE: data discarded; go to REQ with the new pc_reg.
REQ-026 br_taken in KILL SHALL update pc_reg only and stay in KILL until imem_ack.
REQ-027 imem_ack outside REQ/KILL SHALL be ignored.
REQ-028 stall_cnt SHALL increment in every cycle with imem_req=1 and imem_ack=0, saturating at 16'hFFFF.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, pc_reg=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, buffer cleared, stall_cnt=0.
REQ-030 Reset mid-request SHALL abandon the outstanding request; the first post-reset request SHALL be to RESET_PC, issued in the second cycle after rst rises.

Verification
REQ-031 Reset release, memory acks every request the cycle it is issued, freeze=0 -> if_pc sequence 0,4,8,C, one new instruction every 2 cycles.
REQ-032 Ack after 3 wait cycles for addr 0x0 -> imem_addr held at 0x0 for 4 cycles, stall_cnt=3, if_instr equals imem_rdata from the ack cycle.
REQ-033 freeze=1 held while if_valid=1 (pc 0x4) and the ack for 0x8 arrives -> HOLD, output stays 0x4; freeze drops -> output 0x8 next cycle, no lost or duplicated instruction.
REQ-034 br_taken with br_target=0x103 while the request for 0x10 is outstanding -> KILL; the 0x10 data is discarded, if_valid=0, and the next request is to 0x100.
REQ-035 br_taken and freeze=1 in the same cycle as imem_ack -> output flushed (if_valid=0), data dropped, next imem_addr = target.
REQ-036 imem_ack held low for 70000 cycles -> stall_cnt saturates at 0xFFFF.
